// File: rtl/time_keeper.sv
// time_keeper: 1 Hz prescaler plus hh:mm:ss counters with adjust pulses.
// Optional alarm registers and ports are added when CLOCK_ALARM_EN is defined.
module time_keeper #(
  parameter int unsigned CLK_HZ = 100000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       up_seg,
  input  logic       up_min,
  input  logic       up_hour,
  input  logic       down_seg,
  input  logic       down_min,
  input  logic       down_hour,
`ifdef CLOCK_ALARM_EN
  input  logic       alarm_set,
  input  logic       alarm_ack,
  output logic [5:0] alarm_min,
  output logic [4:0] alarm_hour,
  output logic       alarm_hit,
`endif
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [4:0] hour,
  output logic       sec_tick
);
  function automatic logic [5:0] step6(input logic [5:0] v, input logic up, input logic dn);
    return (up && !dn) ? ((v == 6'd59) ? 6'd0 : v + 6'd1) :
           (dn && !up) ? ((v == 6'd0) ? 6'd59 : v - 6'd1) : v;
  endfunction
  function automatic logic [4:0] step5(input logic [4:0] v, input logic up, input logic dn);
    return (up && !dn) ? ((v == 5'd23) ? 5'd0 : v + 5'd1) :
           (dn && !up) ? ((v == 5'd0) ? 5'd23 : v - 5'd1) : v;
  endfunction
  logic [31:0] pre;
  logic        to_time, wrap, edit, tick;
  logic [5:0]  sec_n, min_n;
  logic [4:0]  hour_n;
`ifdef CLOCK_ALARM_EN
  assign to_time = ~alarm_set;
`else
  assign to_time = 1'b1;
`endif
  assign wrap = run && (pre == 32'(CLK_HZ - 1));
  assign edit = to_time && |{up_seg, up_min, up_hour, down_seg, down_min, down_hour};
  // an edit swallows a tick landing in the same cycle
  assign tick = wrap && !edit;
  always_comb begin
    sec_n  = (sec > 6'd59) ? 6'd0 : edit ? step6(sec, up_seg, down_seg) :
             tick ? ((sec == 6'd59) ? 6'd0 : sec + 6'd1) : sec;
    min_n  = (min > 6'd59) ? 6'd0 : edit ? step6(min, up_min, down_min) :
             (tick && sec == 6'd59) ? ((min == 6'd59) ? 6'd0 : min + 6'd1) : min;
    hour_n = (hour > 5'd23) ? 5'd0 : edit ? step5(hour, up_hour, down_hour) :
             (tick && sec == 6'd59 && min == 6'd59) ? ((hour == 5'd23) ? 5'd0 : hour + 5'd1) : hour;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pre      <= '0;
      sec      <= '0;
      min      <= '0;
      hour     <= '0;
      sec_tick <= 1'b0;
    end else begin
      pre      <= (!run || wrap || edit) ? 32'd0 : pre + 32'd1;
      sec      <= sec_n;
      min      <= min_n;
      hour     <= hour_n;
      sec_tick <= tick;
    end
  end
`ifdef CLOCK_ALARM_EN
  logic hit;
  assign hit = tick && sec_n == 6'd0 && min_n == alarm_min && hour_n == alarm_hour;
  always_ff @(posedge clk) begin
    if (reset) begin
      alarm_min  <= '0;
      alarm_hour <= '0;
      alarm_hit  <= 1'b0;
    end else begin
      alarm_min  <= (alarm_min > 6'd59) ? 6'd0 :
                    alarm_set ? step6(alarm_min, up_min, down_min) : alarm_min;
      alarm_hour <= (alarm_hour > 5'd23) ? 5'd0 :
                    alarm_set ? step5(alarm_hour, up_hour, down_hour) : alarm_hour;
      alarm_hit  <= hit ? 1'b1 : alarm_ack ? 1'b0 : alarm_hit;
    end
  end
`endif
endmodule

// File: tb/tb_time_keeper.sv
// tb_time_keeper: directed checks of time_keeper with CLK_HZ=4.
// Alarm scenario is compiled in only when CLOCK_ALARM_EN is defined.
module tb_time_keeper;
  logic clk = 1'b0;
  logic reset, run, up_seg, up_min, up_hour, down_seg, down_min, down_hour;
  logic [5:0] sec, min;
  logic [4:0] hour;
  logic sec_tick;
  int total = 0;
  int bad = 0;
`ifdef CLOCK_ALARM_EN
  logic alarm_set, alarm_ack, alarm_hit;
  logic [5:0] alarm_min;
  logic [4:0] alarm_hour;
`endif

  time_keeper #(.CLK_HZ(4)) dut (
    .clk(clk), .reset(reset), .run(run),
    .up_seg(up_seg), .up_min(up_min), .up_hour(up_hour),
    .down_seg(down_seg), .down_min(down_min), .down_hour(down_hour),
`ifdef CLOCK_ALARM_EN
    .alarm_set(alarm_set), .alarm_ack(alarm_ack), .alarm_min(alarm_min),
    .alarm_hour(alarm_hour), .alarm_hit(alarm_hit),
`endif
    .sec(sec), .min(min), .hour(hour), .sec_tick(sec_tick)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // bits: {up_seg, up_min, up_hour, down_seg, down_min, down_hour}
  task automatic pulse(input logic [5:0] p);
    {up_seg, up_min, up_hour, down_seg, down_min, down_hour} = p;
    cyc(1);
    {up_seg, up_min, up_hour, down_seg, down_min, down_hour} = '0;
  endtask

  task automatic do_reset(input logic run_v);
    reset = 1'b1;
    run = run_v;
    cyc(3);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    {up_seg, up_min, up_hour, down_seg, down_min, down_hour} = '0;
`ifdef CLOCK_ALARM_EN
    alarm_set = 1'b0;
    alarm_ack = 1'b0;
`endif
    do_reset(1'b1);
    total++;
    if ({hour, min, sec, sec_tick} !== 18'd0) begin
      bad++;
      $display("FAIL reset_state got=%0d:%0d:%0d tick=%0b exp=0:0:0 tick=0", hour, min, sec, sec_tick);
    end
  endtask

  task automatic test_tick;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      total++;
      if (sec_tick !== 1'b0 || sec !== 6'd0) begin
        bad++;
        $display("FAIL pre_tick cyc=%0d got tick=%0b sec=%0d exp tick=0 sec=0", i, sec_tick, sec);
      end
    end
    cyc(1);
    total++;
    if (sec_tick !== 1'b1 || sec !== 6'd1) begin
      bad++;
      $display("FAIL first_tick got tick=%0b sec=%0d exp tick=1 sec=1", sec_tick, sec);
    end
    cyc(1);
    total++;
    if (sec_tick !== 1'b0) begin
      bad++;
      $display("FAIL tick_width got=%0b exp=0", sec_tick);
    end
    cyc(59 * 4 - 1);
    total++;
    if (hour !== 5'd0 || min !== 6'd1 || sec !== 6'd0 || sec_tick !== 1'b1) begin
      bad++;
      $display("FAIL sixty_ticks got=%0d:%0d:%0d tick=%0b exp=0:1:0 tick=1", hour, min, sec, sec_tick);
    end
  endtask

  task automatic test_rollover;
    do_reset(1'b0);
    pulse(6'b000111);
    total++;
    if (hour !== 5'd23 || min !== 6'd59 || sec !== 6'd59) begin
      bad++;
      $display("FAIL preload got=%0d:%0d:%0d exp=23:59:59", hour, min, sec);
    end
    run = 1'b1;
    cyc(3);
    total++;
    if (sec !== 6'd59 || sec_tick !== 1'b0) begin
      bad++;
      $display("FAIL pre_rollover got sec=%0d tick=%0b exp sec=59 tick=0", sec, sec_tick);
    end
    cyc(1);
    total++;
    if (hour !== 5'd0 || min !== 6'd0 || sec !== 6'd0 || sec_tick !== 1'b1) begin
      bad++;
      $display("FAIL rollover got=%0d:%0d:%0d tick=%0b exp=0:0:0 tick=1", hour, min, sec, sec_tick);
    end
    cyc(1);
    total++;
    if (sec_tick !== 1'b0) begin
      bad++;
      $display("FAIL rollover_tick_width got=%0b exp=0", sec_tick);
    end
  endtask

  task automatic test_adjust_wrap;
    do_reset(1'b0);
    pulse(6'b000100);
    pulse(6'b100000);
    total++;
    if (sec !== 6'd0 || min !== 6'd0) begin
      bad++;
      $display("FAIL up_sec_wrap got min=%0d sec=%0d exp min=0 sec=0", min, sec);
    end
    pulse(6'b000001);
    total++;
    if (hour !== 5'd23 || min !== 6'd0) begin
      bad++;
      $display("FAIL down_hour_wrap got hour=%0d min=%0d exp hour=23 min=0", hour, min);
    end
    pulse(6'b001000);
    total++;
    if (hour !== 5'd0 || sec !== 6'd0) begin
      bad++;
      $display("FAIL up_hour_wrap got hour=%0d sec=%0d exp hour=0 sec=0", hour, sec);
    end
  endtask

  task automatic test_edit_vs_tick;
    do_reset(1'b1);
    cyc(3);
    pulse(6'b100000);
    total++;
    if (sec !== 6'd1 || sec_tick !== 1'b0) begin
      bad++;
      $display("FAIL edit_drops_tick got sec=%0d tick=%0b exp sec=1 tick=0", sec, sec_tick);
    end
    cyc(3);
    total++;
    if (sec !== 6'd1 || sec_tick !== 1'b0) begin
      bad++;
      $display("FAIL edit_restart_early got sec=%0d tick=%0b exp sec=1 tick=0", sec, sec_tick);
    end
    cyc(1);
    total++;
    if (sec !== 6'd2 || sec_tick !== 1'b1) begin
      bad++;
      $display("FAIL edit_restart_tick got sec=%0d tick=%0b exp sec=2 tick=1", sec, sec_tick);
    end
  endtask

  task automatic test_cancel_and_hold;
    do_reset(1'b0);
    pulse(6'b000010);
    pulse(6'b010010);
    total++;
    if (min !== 6'd59) begin
      bad++;
      $display("FAIL up_down_cancel got=%0d exp=59", min);
    end
    run = 1'b1;
    cyc(4);
    total++;
    if (sec !== 6'd1 || sec_tick !== 1'b1) begin
      bad++;
      $display("FAIL run_tick got sec=%0d tick=%0b exp sec=1 tick=1", sec, sec_tick);
    end
    run = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      total++;
      if (sec_tick !== 1'b0 || sec !== 6'd1 || min !== 6'd59) begin
        bad++;
        $display("FAIL hold cyc=%0d got min=%0d sec=%0d tick=%0b exp min=59 sec=1 tick=0", i, min, sec, sec_tick);
      end
    end
  endtask

`ifdef CLOCK_ALARM_EN
  task automatic test_alarm;
    do_reset(1'b0);
    alarm_set = 1'b1;
    pulse(6'b010000);
    pulse(6'b010000);
    pulse(6'b100000);
    alarm_set = 1'b0;
    total++;
    if (alarm_min !== 6'd2 || alarm_hour !== 5'd0 || min !== 6'd0 || sec !== 6'd0) begin
      bad++;
      $display("FAIL alarm_set got alarm=%0d:%0d time min=%0d sec=%0d exp alarm=0:2 min=0 sec=0", alarm_hour, alarm_min, min, sec);
    end
    pulse(6'b000100);
    pulse(6'b010000);
    run = 1'b1;
    cyc(3);
    total++;
    if (alarm_hit !== 1'b0) begin
      bad++;
      $display("FAIL alarm_early got=%0b exp=0", alarm_hit);
    end
    cyc(1);
    total++;
    if (alarm_hit !== 1'b1 || min !== 6'd2 || sec !== 6'd0) begin
      bad++;
      $display("FAIL alarm_hit got hit=%0b min=%0d sec=%0d exp hit=1 min=2 sec=0", alarm_hit, min, sec);
    end
    run = 1'b0;
    cyc(5);
    total++;
    if (alarm_hit !== 1'b1) begin
      bad++;
      $display("FAIL alarm_hold got=%0b exp=1", alarm_hit);
    end
    alarm_ack = 1'b1;
    cyc(1);
    alarm_ack = 1'b0;
    total++;
    if (alarm_hit !== 1'b0) begin
      bad++;
      $display("FAIL alarm_ack got=%0b exp=0", alarm_hit);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_tick;
    test_rollover;
    test_adjust_wrap;
    test_edit_vs_tick;
    test_cancel_and_hold;
`ifdef CLOCK_ALARM_EN
    test_alarm;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
